// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the controller datapath, the TX scheduler
// and the UART TX frame engine.
interface uart_tx_scheduler_if #(
   parameter int DW = 8
);
   logic            alu_valid;
   logic [2*DW-1:0] alu_data;
   logic            alu_ack;
   logic            rd_valid;
   logic [DW-1:0]   rd_data;
   logic            rd_ack;
   logic            tx_busy;
   logic [DW-1:0]   tx_p_data;
   logic            tx_data_valid;
   logic            sched_busy;
   logic            drop_err;

   modport master (
      output alu_valid, alu_data, rd_valid, rd_data, tx_busy,
      input  alu_ack, rd_ack, tx_p_data, tx_data_valid,
             sched_busy, drop_err
   );

   modport slave (
      input  alu_valid, alu_data, rd_valid, rd_data, tx_busy,
      output alu_ack, rd_ack, tx_p_data, tx_data_valid,
             sched_busy, drop_err
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: arbitrates ALU / register-read payloads into byte frames.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration (default: ALU first).
module uart_tx_scheduler #(
   parameter int DW      = 8,
   parameter int BUSY_TO = 16
) (
   input  logic               CLK,
   input  logic               RST,
   uart_tx_scheduler_if.slave bus
);
   localparam int TW = $clog2(BUSY_TO + 1);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      SEND,
      WAIT_H,
      WAIT_L,
      GAP
   } state_t;

   state_t          state;
   logic [2*DW-1:0] buf_q;
   logic [1:0]      byte_cnt;
   logic [TW-1:0]   to_cnt;
   logic            alu_ack_q;
   logic            rd_ack_q;
   logic            tdv_q;
   logic            sbusy_q;
   logic            drop_q;
   logic [DW-1:0]   p_data_q;
   logic            req;
   logic            pick_rd;

   assign req = bus.alu_valid | bus.rd_valid;

`ifdef UART_TX_SCHED_RR_EN
   logic ptr_rd;

   always_comb begin
      pick_rd = 1'b0;
      unique case (1'b1)
         (bus.alu_valid && bus.rd_valid):  pick_rd = ptr_rd;
         (bus.rd_valid && !bus.alu_valid): pick_rd = 1'b1;
         default:                          pick_rd = 1'b0;
      endcase
   end

   // Preference flips to the loser of every grant.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ptr_rd <= 1'b0;
      end else if (state == IDLE && req && !bus.tx_busy) begin
         ptr_rd <= !pick_rd;
      end
   end
`else
   assign pick_rd = !bus.alu_valid;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         buf_q     <= '0;
         byte_cnt  <= '0;
         to_cnt    <= '0;
         alu_ack_q <= 1'b0;
         rd_ack_q  <= 1'b0;
         tdv_q     <= 1'b0;
         p_data_q  <= '0;
         sbusy_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         alu_ack_q <= 1'b0;
         rd_ack_q  <= 1'b0;
         tdv_q     <= 1'b0;
         drop_q    <= 1'b0;
         unique case (state)
            IDLE: begin
               // Grant decided here so the ack is visible during GRANT.
               if (req && !bus.tx_busy) begin
                  state   <= GRANT;
                  sbusy_q <= 1'b1;
                  if (pick_rd) begin
                     buf_q    <= {{DW{1'b0}}, bus.rd_data};
                     byte_cnt <= 2'd1;
                     rd_ack_q <= 1'b1;
                  end else begin
                     buf_q     <= bus.alu_data;
                     byte_cnt  <= 2'd2;
                     alu_ack_q <= 1'b1;
                  end
               end
            end
            GRANT: begin
               state    <= SEND;
               tdv_q    <= 1'b1;
               p_data_q <= buf_q[DW-1:0];
            end
            SEND: begin
               state  <= WAIT_H;
               to_cnt <= '0;
            end
            WAIT_H: begin
               if (bus.tx_busy) begin
                  state <= WAIT_L;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (to_cnt == TW'(BUSY_TO - 1)) begin
                     state    <= IDLE;
                     sbusy_q  <= 1'b0;
                     drop_q   <= 1'b1;
                     byte_cnt <= '0;
                  end
               end
            end
            WAIT_L: begin
               if (!bus.tx_busy) begin
                  byte_cnt <= byte_cnt - 2'd1;
                  if (byte_cnt == 2'd1) begin
                     state   <= IDLE;
                     sbusy_q <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               state    <= SEND;
               tdv_q    <= 1'b1;
               p_data_q <= buf_q[2*DW-1:DW];
            end
            default: begin
               state   <= IDLE;
               sbusy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.alu_ack       = alu_ack_q;
   assign bus.rd_ack        = rd_ack_q;
   assign bus.tx_data_valid = tdv_q;
   assign bus.tx_p_data     = p_data_q;
   assign bus.sched_busy    = sbusy_q;
   assign bus.drop_err      = drop_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus
// randomized traffic against a timeline-based reference model.
module tb_uart_tx_scheduler;
   localparam int DW      = 8;
   localparam int BUSY_TO = 16;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   uart_tx_scheduler_if #(.DW(DW)) bus ();

   uart_tx_scheduler #(
      .DW     (DW),
      .BUSY_TO(BUSY_TO)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // engine / requester stimulus state
   int rise_in   = 0;
   int hold_left = 0;
   int eng_d     = 1;
   int eng_h     = 10;
   bit eng_never = 0;
   bit eng_rnd   = 0;
   bit man_busy  = 0;
   bit hold_a    = 0;
   bit hold_r    = 0;
   int tdv_used  = 0;
   int tdv_cnt   = 0;

   // observed event logs
   int ack_c[$];
   int ack_w[$];
   int pl_c[$];
   int pl_b[$];
   int dr_c[$];
   int sbf_c[$];
   logic sb_prev = 1'b0;

   // reference model: timeline of expected events
   bit          m_on      = 0;
   bit          act       = 0;
   bit          g_pend    = 0;
   bit          g_rd      = 0;
   bit          pref_rd   = 0;
   bit          n_g;
   bit          n_rd;
   bit          idle_evt;
   logic [15:0] g_data    = '0;
   int          pulse_at  = -1;
   int          rise_lo   = -1;
   int          fall_from = -1;
   int          drop_at   = -1;
   int          left      = 0;
   logic [7:0]  e_pd      = '0;
   logic [7:0]  exp_q[$];
   logic [12:0] e_v;
   logic [12:0] a_v;

   function automatic int qi(int q[$], int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic clear_logs();
      ack_c.delete();
      ack_w.delete();
      pl_c.delete();
      pl_b.delete();
      dr_c.delete();
      sbf_c.delete();
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (bus.alu_ack && !hold_a) bus.alu_valid = 1'b0;
      if (bus.rd_ack && !hold_r) bus.rd_valid = 1'b0;
      if (tdv_cnt != tdv_used) begin
         tdv_used = tdv_cnt;
         if (eng_rnd) begin
            eng_never = ($urandom_range(0, 9) == 0);
            eng_d = ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(1, 3));
            eng_h = $urandom_range(1, 12);
         end
         if (!eng_never) rise_in = eng_d;
      end
      if (rise_in > 0) begin
         rise_in--;
         if (rise_in == 0) hold_left = eng_h;
      end
      bus.tx_busy = man_busy || (hold_left > 0);
      if (hold_left > 0) hold_left--;
   endtask

   always @(negedge CLK) begin
      if (bus.tx_data_valid) tdv_cnt++;
      if (bus.alu_ack || bus.rd_ack) begin
         ack_c.push_back(cyc);
         ack_w.push_back(int'(bus.rd_ack));
      end
      if (bus.tx_data_valid) begin
         pl_c.push_back(cyc);
         pl_b.push_back(int'(bus.tx_p_data));
      end
      if (bus.drop_err) dr_c.push_back(cyc);
      if (sb_prev && !bus.sched_busy) sbf_c.push_back(cyc);
      sb_prev = bus.sched_busy;

      if (m_on) begin
         if (cyc == pulse_at) begin
            if (exp_q.size() > 0) e_pd = exp_q.pop_front();
            else e_pd = 'x;
         end
         e_v = {g_pend && !g_rd, g_pend && g_rd, cyc == pulse_at,
                cyc == drop_at, act, e_pd};
         a_v = {bus.alu_ack, bus.rd_ack, bus.tx_data_valid,
                bus.drop_err, bus.sched_busy, bus.tx_p_data};
         ntests++;
         if (a_v !== e_v) begin
            nfail++;
            $display("FAIL cycle %0d ack_a/ack_r/tdv/drop/busy/data: got %b, expected %b",
                     cyc, a_v, e_v);
         end
      end

      if (!RST) begin
         m_on = 1; act = 0; g_pend = 0; pref_rd = 0;
         pulse_at = -1; rise_lo = -1; fall_from = -1; drop_at = -1;
         left = 0; e_pd = '0; exp_q.delete();
      end else if (m_on) begin
         idle_evt = 0;
         if (g_pend) begin
            pulse_at = cyc + 1;
            left = g_rd ? 1 : 2;
            exp_q.push_back(g_data[7:0]);
            if (!g_rd) exp_q.push_back(g_data[15:8]);
         end
         if (cyc == pulse_at) begin
            rise_lo = cyc + 1;
         end else if (rise_lo >= 0 && cyc >= rise_lo) begin
            if (bus.tx_busy) begin
               fall_from = cyc + 1;
               rise_lo = -1;
            end else if (cyc == rise_lo + BUSY_TO - 1) begin
               drop_at = cyc + 1;
               idle_evt = 1;
               exp_q.delete();
               left = 0;
               rise_lo = -1;
            end
         end else if (fall_from >= 0 && cyc >= fall_from && !bus.tx_busy) begin
            left--;
            fall_from = -1;
            if (left > 0) pulse_at = cyc + 2;
            else idle_evt = 1;
         end
         n_g = !act && (bus.alu_valid || bus.rd_valid) && !bus.tx_busy;
         n_rd = 0;
         if (n_g) begin
`ifdef UART_TX_SCHED_RR_EN
            if (bus.alu_valid && bus.rd_valid) n_rd = pref_rd;
            else n_rd = bus.rd_valid;
            pref_rd = !n_rd;
`else
            n_rd = !bus.alu_valid;
`endif
            g_data = n_rd ? {8'h00, bus.rd_data} : bus.alu_data;
         end
         g_pend = n_g;
         g_rd = n_rd;
         if (n_g) act = 1;
         else if (idle_evt) act = 0;
      end
   end

   int v;
   int fb;
   int na;

   initial begin
      bus.alu_valid = 0; bus.alu_data = '0;
      bus.rd_valid = 0; bus.rd_data = '0;
      bus.tx_busy = 0;
      RST = 0;
      repeat (3) tick();
      chk("reset_outputs", {19'd0, bus.alu_ack, bus.rd_ack, bus.tx_data_valid,
          bus.sched_busy, bus.drop_err, bus.tx_p_data}, 0);
      RST = 1;
      repeat (3) tick();

      // single register read
      clear_logs();
      bus.rd_data = 8'hA5; bus.rd_valid = 1; v = cyc;
      repeat (25) tick();
      chk("rd_ack_count", ack_c.size(), 1);
      chk("rd_ack_who", qi(ack_w, 0), 1);
      chk("rd_ack_latency", qi(ack_c, 0) - v, 1);
      chk("rd_frame_count", pl_c.size(), 1);
      chk("rd_frame_byte", qi(pl_b, 0), 32'hA5);
      chk("rd_frame_latency", qi(pl_c, 0) - v, 2);
      chk("rd_idle_after_busy", qi(sbf_c, 0) - v, 14);

      // two-byte ALU result
      clear_logs();
      bus.alu_data = 16'h1234; bus.alu_valid = 1; v = cyc;
      repeat (35) tick();
      chk("alu_ack_count", ack_c.size(), 1);
      chk("alu_ack_who", qi(ack_w, 0), 0);
      chk("alu_frame_count", pl_c.size(), 2);
      chk("alu_byte0", qi(pl_b, 0), 32'h34);
      chk("alu_byte1", qi(pl_b, 1), 32'h12);
      chk("alu_frame_spacing", qi(pl_c, 1) - qi(pl_c, 0), 13);

      RST = 0;
      tick();
      RST = 1;
      tick();

      // simultaneous requests
      clear_logs();
      bus.alu_data = 16'h1234; bus.rd_data = 8'hA5;
`ifdef UART_TX_SCHED_RR_EN
      hold_a = 1; hold_r = 1; na = 0;
      bus.alu_valid = 1; bus.rd_valid = 1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.alu_ack || bus.rd_ack) na++;
         if (na == 4) break;
      end
      hold_a = 0; hold_r = 0;
      bus.alu_valid = 0; bus.rd_valid = 0;
      repeat (40) tick();
      chk("rr_ack_count", ack_c.size(), 4);
      chk("rr_order0", qi(ack_w, 0), 0);
      chk("rr_order1", qi(ack_w, 1), 1);
      chk("rr_order2", qi(ack_w, 2), 0);
      chk("rr_order3", qi(ack_w, 3), 1);
      chk("rr_frame_count", pl_c.size(), 6);
      chk("rr_byte2", qi(pl_b, 2), 32'hA5);
      chk("rr_byte3", qi(pl_b, 3), 32'h34);
`else
      bus.alu_valid = 1; bus.rd_valid = 1;
      repeat (50) tick();
      chk("both_ack_count", ack_c.size(), 2);
      chk("both_first_alu", qi(ack_w, 0), 0);
      chk("both_second_rd", qi(ack_w, 1), 1);
      chk("both_frame_count", pl_c.size(), 3);
      chk("both_byte0", qi(pl_b, 0), 32'h34);
      chk("both_byte1", qi(pl_b, 1), 32'h12);
      chk("both_byte2", qi(pl_b, 2), 32'hA5);
`endif

      // engine never answers
      clear_logs();
      eng_never = 1;
      bus.alu_data = 16'h1234; bus.alu_valid = 1; v = cyc;
      repeat (30) tick();
      eng_never = 0;
      chk("to_frame_count", pl_c.size(), 1);
      chk("to_drop_count", dr_c.size(), 1);
      chk("to_drop_cycle", qi(dr_c, 0) - qi(pl_c, 0), 17);
      chk("to_idle_cycle", qi(sbf_c, 0), qi(dr_c, 0));

      // reset during WAIT_L of byte 0
      clear_logs();
      bus.alu_data = 16'h1234; bus.alu_valid = 1; v = cyc;
      repeat (6) tick();
      RST = 0;
      tick();
      chk("rst_outputs", {19'd0, bus.alu_ack, bus.rd_ack, bus.tx_data_valid,
          bus.sched_busy, bus.drop_err, bus.tx_p_data}, 0);
      RST = 1;
      bus.rd_data = 8'hC3; bus.rd_valid = 1;
      repeat (30) tick();
      chk("rst_frame_count", pl_c.size(), 2);
      chk("rst_byte0", qi(pl_b, 0), 32'h34);
      chk("rst_fresh_rd", qi(pl_b, 1), 32'hC3);
      chk("rst_rd_ack_cycle", qi(ack_c, 1) - v, 14);

      // engine busy while a request arrives
      clear_logs();
      man_busy = 1;
      tick();
      bus.rd_data = 8'h5A; bus.rd_valid = 1;
      repeat (4) tick();
      man_busy = 0;
      tick();
      fb = cyc;
      repeat (30) tick();
      chk("busy_idle_ack_cycle", qi(ack_c, 0) - fb, 1);
      chk("busy_idle_byte", qi(pl_b, 0), 32'h5A);

      // randomized traffic
      eng_rnd = 1;
      for (int i = 0; i < 4000; i++) begin
         tick();
         RST = ($urandom_range(0, 599) != 0);
         if (!bus.alu_valid && !bus.alu_ack && $urandom_range(0, 5) == 0) begin
            bus.alu_valid = 1; bus.alu_data = 16'($urandom);
         end else if (bus.alu_valid && $urandom_range(0, 40) == 0) begin
            bus.alu_valid = 0;
         end else if (!bus.alu_valid) begin
            bus.alu_data = 16'($urandom);
         end
         if (!bus.rd_valid && !bus.rd_ack && $urandom_range(0, 5) == 0) begin
            bus.rd_valid = 1; bus.rd_data = 8'($urandom);
         end else if (bus.rd_valid && $urandom_range(0, 40) == 0) begin
            bus.rd_valid = 0;
         end else if (!bus.rd_valid) begin
            bus.rd_data = 8'($urandom);
         end
      end
      RST = 1;
      bus.alu_valid = 0; bus.rd_valid = 0;
      eng_rnd = 0; eng_never = 0; eng_d = 1; eng_h = 3;
      repeat (60) tick();
      chk("drained_idle", {31'd0, bus.sched_busy}, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the UART transmit path: arbitrates two system requesters, serialises their payloads into byte frames, and drives the TX frame engine's parallel-data/data_valid interface.
- Requesters:
  - ALU result: 2*DW bits, sent as two frames, low byte first.
  - Register-file read: DW bits, sent as one frame.
- Sits in the system-controller domain, between the controller datapath and the TX frame engine.

Parameters:
- DW, 8: frame data width in bits.
- BUSY_TO, 16: maximum cycles to wait for tx_busy to rise after a tx_data_valid pulse.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result pending; held high until alu_ack.
- alu_data  in  2*DW  ALU result.
- alu_ack  out  1  one-cycle pulse; ALU result captured.
- rd_valid  in  1  register read data pending; held high until rd_ack.
- rd_data  in  DW  register read data.
- rd_ack  out  1  one-cycle pulse; read data captured.
- tx_busy  in  1  TX frame engine busy; already synchronised into CLK.
- tx_p_data  out  DW  byte presented to the TX frame engine.
- tx_data_valid  out  1  one-cycle frame-start pulse.
- sched_busy  out  1  high in every state except IDLE.
- drop_err  out  1  one-cycle pulse; a frame was not accepted within BUSY_TO.

Behaviour:
- Reset: the reset is synchronous, active-low; when RST=0 at a CLK edge, the following take effect:
  - FSM goes to IDLE.
  - Outputs: all acks 0, tx_data_valid 0, tx_p_data 0, sched_busy 0, drop_err 0.
  - Internal byte buffer, byte counter and timeout counter are cleared.
  - Priority pointer goes to ALU.
  - Reset mid-transfer abandons the transfer; no ack is issued for it.
- States: IDLE, GRANT, SEND, WAIT_H, WAIT_L, GAP.
- IDLE: if any valid is high and tx_busy=0, go to GRANT.
- GRANT (1 cycle):
  - Select a requester: fixed priority, ALU over RD.
  - Latch its data into the 2*DW buffer.
  - Set the byte count: ALU=2, RD=1.
  - Pulse the matching ack (registered, visible in this cycle's outputs).
  - Go to SEND.
  - If no valid is high any longer, return to IDLE with no ack.
- SEND (1 cycle):
  - tx_p_data = current byte (buffer[DW-1:0] for the first byte, buffer[2*DW-1:DW] for the second).
  - tx_data_valid = 1.
  - Clear the timeout counter; go to WAIT_H.
  - tx_p_data holds its value until the next SEND.
- WAIT_H:
  - When tx_busy=1, go to WAIT_L.
  - Otherwise increment the timeout counter. When it reaches BUSY_TO, pulse drop_err, discard all remaining bytes of this request, and go to IDLE.
- WAIT_L: wait for tx_busy=0, then decrement the byte count.
  - If bytes remain, go to GAP.
  - If none remain, go to IDLE.
- GAP (1 cycle): advance to the next byte, go to SEND. This guarantees at least one idle-busy cycle between frames.
- Latency: valid high in IDLE with tx_busy=0 gives ack at +1 and tx_data_valid at +2 cycles.
- Simultaneous requests: the winner's full payload completes before the other is considered. The loser's valid must stay high; it is served next.
- A valid that drops before GRANT is ignored. Changes to a requester's data after its ack do not affect the transfer.
- tx_busy high in IDLE (engine still draining): no grant until it falls.
- tx_busy falling in WAIT_H without ever rising counts toward the timeout; it is not a completion.
- sched_busy = 1 in GRANT, SEND, WAIT_H, WAIT_L and GAP.

Optional Feature:
- Macro: UART_TX_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After a grant, the pointer moves to the other requester.
  - Under both valids held continuously, ALU and RD alternate.
- Undefined: fixed priority, ALU over RD. The pointer logic is absent, and RD is starved while alu_valid stays high.

Test Plan:
- Single RD, DW=8:
  - Stimulus: rd_data=8'hA5, rd_valid=1; model engine raises busy 1 cycle after the pulse and holds it 10 cycles.
  - Required: rd_ack pulse at +1, one tx_data_valid with tx_p_data=8'hA5, sched_busy back to 0 one cycle after busy falls.
- ALU two-byte:
  - Stimulus: alu_data=16'h1234.
  - Required: frames 8'h34 then 8'h12, at least 1 GAP cycle between busy falling and the second tx_data_valid, exactly one alu_ack.
- Simultaneous alu_valid and rd_valid, both held:
  - Without macro: ALU bytes 34, 12 go out, then RD A5.
  - With UART_TX_SCHED_RR_EN, both held for 4 grants: order ALU, RD, ALU, RD.
- Timeout:
  - Stimulus: engine never raises tx_busy.
  - Required: drop_err pulses exactly BUSY_TO=16 cycles after WAIT_H entry; an ALU request's second byte is not sent; FSM returns to IDLE.
- Reset mid-frame:
  - Stimulus: RST=0 for 1 cycle during WAIT_L of an ALU byte 0.
  - Required: next cycle all outputs are 0, no second byte, and a fresh rd_valid is served normally after release.
- Busy-at-idle:
  - Stimulus: tx_busy=1 while rd_valid rises.
  - Required: no rd_ack until the cycle after tx_busy falls.
